// File: rtl/retospect_bs_pkg.sv
// Shared types and constants for the neurochip configuration-chain loader.
// Chain = clockbox (48 bits) followed by 16 CNBs of 19 bits each.
package retospect_bs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } bs_state_t;

  localparam int CLOCKBOX_BITS     = 48;
  localparam int CNB_BITS          = 19;
  localparam int CNB_COUNT         = 16;
  localparam int CHAIN_LEN_DEFAULT = CLOCKBOX_BITS + CNB_COUNT * CNB_BITS;

endpackage

// File: rtl/retospect_bs_deser.sv
// Reassembles bits leaving the chain tail into bytes (first bit out in bit0),
// with a single holding register handshaked by rd_valid/rd_ready.
module retospect_bs_deser (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic       bit_in,
  input  logic       last_bit,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid
);

  logic [7:0] acc_reg;
  logic [7:0] acc_next;
  logic [2:0] idx_reg;
  logic [7:0] rd_data_reg;
  logic       rd_valid_reg;
  logic       byte_done;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_acc
      assign acc_next[gi] = acc_reg[gi] | (bit_in & (idx_reg == 3'(gi)));
    end
  endgenerate

  // A short final byte completes early; its unset MSBs stay zero.
  assign byte_done = sample_en & ((idx_reg == 3'd7) | last_bit);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg      <= '0;
      idx_reg      <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      if (byte_done) begin
        acc_reg <= '0;
        idx_reg <= '0;
      end else if (sample_en) begin
        acc_reg <= acc_next;
        idx_reg <= idx_reg + 3'd1;
      end
      if (byte_done) begin
        rd_data_reg  <= acc_next;
        rd_valid_reg <= 1'b1;
      end else if (rd_ready) begin
        rd_valid_reg <= 1'b0;
      end
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;

endmodule

// File: rtl/retospect_bs_loader.sv
// Host-side loader for the configuration shift chain: bytes in LSB-first,
// optional readback of the chain tail when RETOSPECT_BS_READBACK_EN is defined.
module retospect_bs_loader
  import retospect_bs_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       busy,
  output logic       done,
  output logic       config_en,
  output logic       bs_to_chain,
  input  logic       bs_from_chain
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN);

  bs_state_t        state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [3:0]       byte_bits_reg, byte_bits_next;
  logic [7:0]       sreg_reg, sreg_next;
  logic             config_en_reg, config_en_next;
  logic             bs_reg, bs_next;
  logic             room;

`ifdef RETOSPECT_BS_READBACK_EN
  logic rd_valid_int;
  logic last_bit;

  assign last_bit = config_en_reg & (count_reg == LAST_CNT);

  retospect_bs_deser u_deser (
    .clk       (clk),
    .reset     (reset),
    .sample_en (config_en_reg),
    .bit_in    (bs_from_chain),
    .last_bit  (last_bit),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid_int)
  );

  assign rd_valid = rd_valid_int;
  // Never start a byte whose readback would overwrite an unread one.
  assign room     = ~rd_valid_int | rd_ready;
`else
  logic unused_rd;
  assign unused_rd = ^{rd_ready, bs_from_chain};
  assign rd_valid  = 1'b0;
  assign rd_data   = 8'h00;
  assign room      = 1'b1;
`endif

  assign wr_ready = (state_reg == FETCH) & room;

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    byte_bits_next = byte_bits_reg;
    sreg_next      = sreg_reg;
    config_en_next = 1'b0;
    bs_next        = bs_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          count_next = '0;
        end
      end
      FETCH: begin
        if (wr_valid && wr_ready) begin
          state_next     = SHIFT;
          sreg_next      = wr_data;
          byte_bits_next = 4'd1;
          count_next     = count_reg + CNT_W'(1);
          config_en_next = 1'b1;
          bs_next        = wr_data[0];
        end
      end
      SHIFT: begin
        if (byte_bits_reg == 4'd8 || count_reg == LAST_CNT) begin
          state_next = (count_reg == LAST_CNT) ? DONE : FETCH;
        end else begin
          config_en_next = 1'b1;
          bs_next        = sreg_reg[byte_bits_reg[2:0]];
          byte_bits_next = byte_bits_reg + 4'd1;
          count_next     = count_reg + CNT_W'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      byte_bits_reg <= '0;
      sreg_reg      <= '0;
      config_en_reg <= 1'b0;
      bs_reg        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      byte_bits_reg <= byte_bits_next;
      sreg_reg      <= sreg_next;
      config_en_reg <= config_en_next;
      bs_reg        <= bs_next;
    end
  end

  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);
  assign config_en   = config_en_reg;
  assign bs_to_chain = bs_reg;

endmodule
